pipe_stage_skid: RTL

- Parametrised successor to the fixed IF/ID pipeline register.
- Generic pipeline stage register with valid/ready handshake and a 2-entry skid buffer. Stalls propagate without a combinational ready path.
- Supports synchronous flush with optional payload zeroing.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, ...). The payload is the concatenated stage bundle, e.g. {pcplus4, pc, instruction}.

---
 rtl/pipe_stage_skid.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Generic pipeline stage register with a valid/ready handshake
//               and a 2-entry skid buffer (main register M, skid register S).
//               in_ready and out_valid come straight from flops, so a stall
//               does not create a combinational path from out_ready to
//               in_ready. A synchronous flush discards held entries. With
//               FLUSH_ZERO set, the flush also clears the payload to a
//               NOP-equivalent all-zero bundle.
//               Optional build macro PIPE_STAGE_PERF_EN adds two saturating
//               performance counters: stall_cnt and flush_cnt.
// Revision    : 1.0 - initial parametrised release replacing fixed IF/ID reg
// ============================================================================
module pipe_stage_skid #(
  parameter int DATA_W     = 96,
  parameter int FLUSH_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // Occupancy of the two-entry buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   main_q;
  logic [DATA_W-1:0]   skid_q;

  logic                in_fire;
  logic                out_fire;
  logic                load_main;
  logic                main_from_skid;
  logic                load_skid;

  // Handshake completion uses the registered flags only
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  // Next-state and register-load decode
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Any in_fire this cycle is consumed upstream but discarded here; an
      // out_fire completes downstream because out_valid was already high.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain can happen
          if (out_fire) begin
            state_d        = ST_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State register with registered handshake flags derived from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Payload registers: M only moves on load or flush, so out_data is stable
  // while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      if (FLUSH_ZERO != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Saturating counters of stalled cycles and of flushes that discarded data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
